// File: rtl/sram_dual_responder.sv
// Shared inst/data word memory with two synchronous read-first ports and byte-lane writes.
// Optional SRAM_WR_BYPASS_EN forwards same-cycle cross-port writes into the other port's read.
module sram_dual_responder #(
  parameter int    ADDR_W    = 14,
  parameter string INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_en,
  input  logic [3:0]  inst_sram_we,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        addr_err
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0] mem_q [0:DEPTH-1];

  logic [ADDR_W-1:0] i_idx, d_idx;
  logic              i_ok, d_ok;
  logic              i_acc, d_acc;
  logic              i_bad, d_bad;
  logic              i_wr, d_wr;
  logic [31:0]       i_word, d_word;
  logic [31:0]       i_rdata_d, i_rdata_q;
  logic [31:0]       d_rdata_d, d_rdata_q;
  logic              err_d, err_q;
  logic              unused_ok;

  assign unused_ok = ^{inst_sram_addr[1:0], data_sram_addr[1:0]};

  assign i_idx = inst_sram_addr[ADDR_W+1:2];
  assign d_idx = data_sram_addr[ADDR_W+1:2];
  assign i_ok  = (inst_sram_addr[31:ADDR_W+2] == '0);
  assign d_ok  = (data_sram_addr[31:ADDR_W+2] == '0);
  assign i_acc = inst_sram_en & i_ok;
  assign d_acc = data_sram_en & d_ok;
  assign i_bad = inst_sram_en & ~i_ok;
  assign d_bad = data_sram_en & ~d_ok;
  assign i_wr  = i_acc & (|inst_sram_we);
  assign d_wr  = d_acc & (|data_sram_we);

`ifdef SRAM_WR_BYPASS_EN
  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  we
  );
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++)
      if (we[k]) r[8*k +: 8] = wd[8*k +: 8];
    return r;
  endfunction

  always_comb begin
    i_word = mem_q[i_idx];
    d_word = mem_q[d_idx];
    if (d_wr && d_idx == i_idx)
      i_word = merge(mem_q[i_idx], data_sram_wdata, data_sram_we);
    if (i_wr && i_idx == d_idx)
      d_word = merge(mem_q[d_idx], inst_sram_wdata, inst_sram_we);
  end
`else
  assign i_word = mem_q[i_idx];
  assign d_word = mem_q[d_idx];
`endif

  always_comb begin
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    if (i_acc)      i_rdata_d = i_word;
    else if (i_bad) i_rdata_d = 32'h0;
    if (d_acc)      d_rdata_d = d_word;
    else if (d_bad) d_rdata_d = 32'h0;
  end

  assign err_d = err_q | i_bad | d_bad;

  // Inst lanes first so data lanes override on the same word.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (i_wr && inst_sram_we[k])
        mem_q[i_idx][8*k +: 8] <= inst_sram_wdata[8*k +: 8];
    for (int k = 0; k < 4; k++)
      if (d_wr && data_sram_we[k])
        mem_q[d_idx][8*k +: 8] <= data_sram_wdata[8*k +: 8];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      i_rdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      err_q     <= err_d;
    end
  end

  assign inst_sram_rdata = i_rdata_q;
  assign data_sram_rdata = d_rdata_q;
  assign addr_err        = err_q;

endmodule

// File: tb/tb_sram_dual_responder.sv
// Directed bench for sram_dual_responder with a read-data scoreboard.
// Expectations follow SRAM_WR_BYPASS_EN when it is defined for the build.
module tb_sram_dual_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        ien, den;
  logic [3:0]  iwe, dwe;
  logic [31:0] iaddr, daddr, iwd, dwd;
  logic [31:0] irdata, drdata;
  logic        addr_err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    bit          port;
    logic [31:0] exp;
    string       tag;
  } sb_t;

  sb_t sb[$];

  sram_dual_responder #(.ADDR_W(14)) dut (
    .clk(clk),
    .resetn(resetn),
    .inst_sram_en(ien),
    .inst_sram_we(iwe),
    .inst_sram_addr(iaddr),
    .inst_sram_wdata(iwd),
    .inst_sram_rdata(irdata),
    .data_sram_en(den),
    .data_sram_we(dwe),
    .data_sram_addr(daddr),
    .data_sram_wdata(dwd),
    .data_sram_rdata(drdata),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    ien = 0; iwe = 0; iaddr = 0; iwd = 0;
    den = 0; dwe = 0; daddr = 0; dwd = 0;
  endtask

  // Drive one cycle of stimulus, clock it, then check every queued result.
  task automatic step(
    input logic ie, input logic [3:0] iw, input logic [31:0] ia,
    input logic [31:0] id,
    input logic de, input logic [3:0] dw, input logic [31:0] da,
    input logic [31:0] dd,
    input bit ic, input logic [31:0] iexp,
    input bit dc, input logic [31:0] dexp,
    input string tag
  );
    sb_t e;
    ien = ie; iwe = iw; iaddr = ia; iwd = id;
    den = de; dwe = dw; daddr = da; dwd = dd;
    if (ic) sb.push_back('{1'b0, iexp, {tag, "_inst"}});
    if (dc) sb.push_back('{1'b1, dexp, {tag, "_data"}});
    @(posedge clk);
    #1;
    idle_in();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, e.port ? drdata : irdata, e.exp);
    end
  endtask

  logic [31:0] exp_conf, exp_part;

  initial begin
`ifdef SRAM_WR_BYPASS_EN
    exp_conf = 32'hCAFE0000;
    exp_part = 32'h123456FF;
`else
    exp_conf = 32'h00000000;
    exp_part = 32'h12345678;
`endif
    idle_in();
    resetn = 1'b0;
    #2;
    chk("rst_irdata", irdata, 32'h0);
    chk("rst_drdata", drdata, 32'h0);
    chk("rst_err", {31'h0, addr_err}, 32'h0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // write then read back next cycle
    step(0,0,0,0, 1,4'hF,32'h1C0,32'hDEADBEEF, 0,0, 0,0, "wr1c0");
    step(0,0,0,0, 1,4'h0,32'h1C0,32'h0, 0,0, 1,32'hDEADBEEF, "rd1c0");

    // byte lanes
    step(0,0,0,0, 1,4'hF,32'h40,32'h11223344, 0,0, 0,0, "wr40");
    step(0,0,0,0, 1,4'b0100,32'h40,32'h00AA0000, 0,0, 0,0, "wr40b");
    step(1,4'h0,32'h40,0, 1,4'h0,32'h40,0, 1,32'h11AA3344,
         1,32'h11AA3344, "rd40");
    step(0,0,0,0, 0,4'hF,32'h40,32'hFFFFFFFF, 1,32'h11AA3344,
         1,32'h11AA3344, "hold");
    step(0,0,0,0, 1,4'h0,32'h40,0, 0,0, 1,32'h11AA3344, "noen_wr");

    // cross-port conflict
    step(0,0,0,0, 1,4'hF,32'h80,32'h0, 0,0, 0,0, "clr80");
    step(0,0,0,0, 1,4'hF,32'h84,32'h12345678, 0,0, 0,0, "wr84");
    step(1,4'h0,32'h80,0, 1,4'hF,32'h80,32'hCAFE0000, 1,exp_conf,
         0,0, "conf80");
    step(1,4'h0,32'h80,0, 0,0,0,0, 1,32'hCAFE0000, 0,0, "after80");
    step(1,4'h0,32'h84,0, 1,4'b0001,32'h84,32'h000000FF, 1,exp_part,
         0,0, "conf84");
    step(1,4'h0,32'h84,0, 0,0,0,0, 1,32'h123456FF, 0,0, "after84");

    // dual write, data wins overlapping lanes
    step(1,4'hF,32'h100,32'hAAAAAAAA, 1,4'b0011,32'h100,32'h00005555,
         0,0, 0,0, "dual100");
    step(1,4'h0,32'h100,0, 1,4'h0,32'h100,0, 1,32'hAAAA5555,
         1,32'hAAAA5555, "rd100");

    // inst port write and same-port readback
    step(1,4'b1001,32'h100,32'h77000088, 0,0,0,0, 0,0, 0,0, "iwr100");
    step(1,4'h0,32'h100,0, 0,0,0,0, 1,32'h77AA5588, 0,0, "ird100");

    // top in-range word, then out of range
    step(0,0,0,0, 1,4'hF,32'h0000FFFC,32'h5A5A5A5A, 0,0, 0,0, "wrtop");
    step(0,0,0,0, 1,4'h0,32'h0000FFFC,0, 0,0, 1,32'h5A5A5A5A, "rdtop");
    chk("err_inrange", {31'h0, addr_err}, 32'h0);
    step(0,0,0,0, 1,4'hF,32'h0,32'h0BADF00D, 0,0, 0,0, "wr0");
    step(0,0,0,0, 1,4'hF,32'h00010000,32'h12345678, 0,0, 1,32'h0, "oob");
    chk("err_set", {31'h0, addr_err}, 32'h1);
    step(0,0,0,0, 1,4'h0,32'h0,0, 0,0, 1,32'h0BADF00D, "alias0");
    for (int i = 0; i < 10; i++) step(0,0,0,0, 0,0,0,0, 0,0, 0,0, "idle");
    chk("err_held", {31'h0, addr_err}, 32'h1);

    // asynchronous reset mid-run
    step(1,4'h0,32'h40,0, 0,0,0,0, 1,32'h11AA3344, 0,0, "pre_rst");
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_irdata", irdata, 32'h0);
    chk("arst_drdata", drdata, 32'h0);
    chk("arst_err", {31'h0, addr_err}, 32'h0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    step(0,0,0,0, 1,4'h0,32'h1C0,0, 0,0, 1,32'hDEADBEEF, "post_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
